// File: rtl/bist_response_checker.sv
// BIST output-response analyzer: compares ALU responses against golden ROM words,
// counts mismatches, captures the first failure and compacts responses into a MISR.
module bist_response_checker #(
    parameter int                DATA_W    = 9,
    parameter int                ADDR_W    = 8,
    parameter int                LEN       = 256,
    parameter logic [DATA_W-1:0] MISR_POLY = 9'h011,
    parameter logic [DATA_W-1:0] MISR_SEED = 9'h000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              valid,
    input  logic [DATA_W-1:0] alu_data,
    input  logic [DATA_W-1:0] rom_data,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W-1:0] vec_idx,
    output logic [ADDR_W:0]   fail_count,
    output logic              first_fail_valid,
    output logic [ADDR_W-1:0] first_fail_idx,
    output logic [DATA_W-1:0] first_fail_got,
    output logic [DATA_W-1:0] signature
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(LEN - 1);

    state_t            state, state_nxt;
    logic              accept;
    logic              mismatch;
    logic              last;
    logic [ADDR_W:0]   fail_nxt;
    logic [DATA_W-1:0] misr_nxt;

    always_comb begin
        accept   = (state == RUN) && valid;
        // Case inequality so an unknown bit on the response is treated as a failure.
        mismatch = (alu_data !== rom_data);
        last     = (vec_idx == LAST_IDX);
        fail_nxt = (mismatch && (fail_count != '1)) ? fail_count + 1'b1 : fail_count;
        misr_nxt = {signature[DATA_W-2:0], 1'b0}
                 ^ (signature[DATA_W-1] ? MISR_POLY : '0)
                 ^ alu_data;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (accept && last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pass             <= 1'b0;
            vec_idx          <= '0;
            fail_count       <= '0;
            first_fail_valid <= 1'b0;
            first_fail_idx   <= '0;
            first_fail_got   <= '0;
            signature        <= MISR_SEED;
        end else if (state == IDLE && start) begin
            pass             <= 1'b0;
            vec_idx          <= '0;
            fail_count       <= '0;
            first_fail_valid <= 1'b0;
            first_fail_idx   <= '0;
            first_fail_got   <= '0;
            signature        <= MISR_SEED;
        end else if (accept) begin
            vec_idx    <= vec_idx + 1'b1;
            fail_count <= fail_nxt;
            signature  <= misr_nxt;
            if (mismatch && !first_fail_valid) begin
                first_fail_valid <= 1'b1;
                first_fail_idx   <= vec_idx;
                first_fail_got   <= alu_data;
            end
            // Verdict includes the final vector, so it uses the post-update count.
            if (last) pass <= (fail_nxt == '0);
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule
